// File: rtl/riego_pkg.sv
// Shared types and defaults for the irrigation zone scheduler.
package riego_pkg;

    localparam int unsigned N_ZONES_DEF   = 4;
    localparam int unsigned MAX_SPEED_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        RAMP_UP,
        WATER,
        RAMP_DOWN,
        CLOSE,
        COOLDOWN
    } state_e;

    // True on the last cycle of a phase that lasts len cycles; len of 0 behaves like 1.
    function automatic logic phase_done(input logic [31:0] cnt, input int unsigned len);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, len};
    endfunction

endpackage

// File: rtl/riego_rr_arbiter.sv
// Round-robin zone picker: searches from the zone after the last grant, wrapping.
module riego_rr_arbiter
    import riego_pkg::*;
#(
    parameter  int unsigned N_ZONES = N_ZONES_DEF,
    localparam int unsigned ZW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] i_req,
    input  logic               i_take,
    output logic               o_any,
    output logic [ZW-1:0]      o_pick
);

    logic [ZW-1:0] r_last;
    logic [ZW-1:0] w_idx;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        o_any  = 1'b0;
        o_pick = r_last;
        w_idx  = '0;
        for (int k = 1; k <= int'(N_ZONES); k++) begin
            w_idx = ZW'((int'(r_last) + k) % int'(N_ZONES));
            if (!o_any && i_req[w_idx]) begin
                o_any  = 1'b1;
                o_pick = w_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ZW'(N_ZONES - 1);
        end else if (i_take) begin
            r_last <= o_pick;
        end
    end

endmodule

// File: rtl/riego_zone_scheduler.sv
// Shared-pump irrigation sequencer: grant a zone, open its valve, ramp the pump up,
// water, ramp down, close and cool down before the next zone.
module riego_zone_scheduler
    import riego_pkg::*;
#(
    parameter  int unsigned N_ZONES      = N_ZONES_DEF,
    parameter  int unsigned RAMP_DELAY   = 1000000,
    parameter  int unsigned MAX_SPEED    = MAX_SPEED_DEF,
    parameter  int unsigned VALVE_SETTLE = 5000000,
    parameter  int unsigned WATER_CYCLES = 250000000,
    parameter  int unsigned COOL_CYCLES  = 50000000,
    localparam int unsigned ZW           = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] zone_req,
    input  logic               stop_all,
    output logic               pump_enable,
    output logic [7:0]         pump_speed,
    output logic [N_ZONES-1:0] valve,
    output logic [ZW-1:0]      active_zone,
    output logic               busy,
    output logic [N_ZONES-1:0] zone_done
);

    localparam logic [7:0] SPD_MAX = 8'(MAX_SPEED);

    state_e             r_state,  w_state_nxt;
    logic [31:0]        r_cnt,    w_cnt_nxt;
    logic [7:0]         r_speed,  w_speed_nxt;
    logic [ZW-1:0]      r_grant,  w_grant_nxt;
    logic               r_enable, w_enable_nxt;
    logic [N_ZONES-1:0] r_valve,  w_valve_nxt;
    logic [N_ZONES-1:0] r_done,   w_done_nxt;
    logic               r_busy;
    logic [N_ZONES-1:0] w_onehot;
    logic               w_any;
    logic [ZW-1:0]      w_pick;
    logic               w_take;
    logic               w_abort;

    riego_rr_arbiter #(.N_ZONES(N_ZONES)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (zone_req),
        .i_take (w_take),
        .o_any  (w_any),
        .o_pick (w_pick)
    );

    // stop_all and a dropped request of the granted zone both cut the sequence short.
    assign w_abort = stop_all || !zone_req[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 32'd1;
        w_speed_nxt = r_speed;
        w_grant_nxt = r_grant;
        w_take      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_any && !stop_all) begin
                    w_take      = 1'b1;
                    w_grant_nxt = w_pick;
                    w_state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (w_abort)                               w_state_nxt = CLOSE;
                else if (phase_done(r_cnt, VALVE_SETTLE))  w_state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (w_abort) begin
                    w_state_nxt = RAMP_DOWN;
                end else if (r_speed >= SPD_MAX) begin
                    w_state_nxt = WATER;
                end else if (phase_done(r_cnt, RAMP_DELAY)) begin
                    w_speed_nxt = r_speed + 8'd1;
                    w_cnt_nxt   = '0;
                    if (r_speed + 8'd1 >= SPD_MAX) w_state_nxt = WATER;
                end
            end
            WATER: begin
                if (w_abort || phase_done(r_cnt, WATER_CYCLES)) w_state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (r_speed == 8'd0) begin
                    w_state_nxt = CLOSE;
                end else if (phase_done(r_cnt, RAMP_DELAY)) begin
                    w_speed_nxt = r_speed - 8'd1;
                    w_cnt_nxt   = '0;
                    if (r_speed == 8'd1) w_state_nxt = CLOSE;
                end
            end
            CLOSE:    w_state_nxt = COOLDOWN;
            COOLDOWN: begin
                if (phase_done(r_cnt, COOL_CYCLES)) w_state_nxt = IDLE;
            end
            default:  w_state_nxt = IDLE;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Output values are derived from the next state so the registered outputs line up with it.
    always_comb begin
        w_onehot              = '0;
        w_onehot[w_grant_nxt] = 1'b1;
        w_enable_nxt = (w_state_nxt == RAMP_UP) || (w_state_nxt == WATER) ||
                       (w_state_nxt == RAMP_DOWN);
        w_valve_nxt  = (w_enable_nxt || (w_state_nxt == OPEN)) ? w_onehot : '0;
        w_done_nxt   = (w_state_nxt == CLOSE) ? w_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_speed  <= '0;
            r_grant  <= '0;
            r_enable <= 1'b0;
            r_valve  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_speed  <= w_speed_nxt;
            r_grant  <= w_grant_nxt;
            r_enable <= w_enable_nxt;
            r_valve  <= w_valve_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign pump_enable = r_enable;
    assign pump_speed  = r_speed;
    assign valve       = r_valve;
    assign active_zone = r_grant;
    assign busy        = r_busy;
    assign zone_done   = r_done;

endmodule
